// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared forward-select codes and memory-wait FSM states for
//            hazard_ctrl_mc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/md_busy_tracker.sv
// ============================================================================
// Module   : md_busy_tracker
// Purpose  : Occupancy counter for the multi-cycle multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_busy_tracker #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_e,
    input  logic mem_stall,
    output logic md_busy,
    output logic md_accept
);

    localparam int             CW      = $clog2(MD_LATENCY + 1);
    localparam logic [CW-1:0]  LAT_CNT = CW'(MD_LATENCY);

    logic [CW-1:0] md_cnt;

    assign md_busy   = (md_cnt != '0);
    // A frozen pipeline cannot hand the op to the unit; a busy unit refuses it.
    assign md_accept = md_start_e && !mem_stall && !md_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt <= '0;
        end else if (md_accept) begin
            md_cnt <= LAT_CNT;
        end else if (md_busy) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
// ============================================================================
// Module   : hazard_ctrl_mc
// Purpose  : MIPS 5-stage hazard controller: forwarding, load-use/branch/
//            mul-div stalls, jump flush and variable-latency memory freeze.
//            Optional macro HAZARD_PERF_EN adds stall/flush cycle counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MD_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RsE,
    input  logic [REG_W-1:0]  RtE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic [REG_W-1:0]  WriteRegW,
    input  logic              BranchD,
    input  logic              jumpD,
    input  logic              MemtoRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegM,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MdStartD,
    input  logic              MdStartE,
    input  logic              MdReadD,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushE,
    output logic              FlushW,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdBusy,
    output logic              MemErr,
    output logic [PERF_W-1:0] StallCycles,
    output logic [PERF_W-1:0] FlushCycles
);

    localparam int              WCW         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0]  TIMEOUT_CNT = WCW'(MEM_TIMEOUT);

    mem_state_t     state, state_next;
    logic [WCW-1:0] wait_cnt, wait_cnt_next;
    logic           mem_miss, timeout_hit, memstall;
    logic           md_busy, md_accept;
    logic           lwstall, branchstall, mdstall, hazard_stall;
    logic [1:0]     fwd_ae, fwd_be;

    assign mem_miss    = MemReqM && !MemReadyM;
    assign timeout_hit = mem_miss && (wait_cnt == TIMEOUT_CNT);
    assign memstall    = mem_miss && !timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (mem_miss) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WCW'(1);
                end
            end
            MEM_WAIT: begin
                // Ready, dropped request or timeout all end the access.
                if (!mem_miss || timeout_hit) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_tracker (
        .clk        (clk),
        .rst        (reset),
        .md_start_e (MdStartE),
        .mem_stall  (memstall),
        .md_busy    (md_busy),
        .md_accept  (md_accept)
    );

    assign MdBusy = md_busy;

    assign fwd_ae = (RsE != '0 && RsE == WriteRegM && RegWriteM) ? FWD_MEM :
                    (RsE != '0 && RsE == WriteRegW && RegWriteW) ? FWD_WB  : FWD_RF;
    assign fwd_be = (RtE != '0 && RtE == WriteRegM && RegWriteM) ? FWD_MEM :
                    (RtE != '0 && RtE == WriteRegW && RegWriteW) ? FWD_WB  : FWD_RF;

    assign lwstall     = MemtoRegE && (RtE != '0) && (RsD == RtE || RtD == RtE);
    assign branchstall = BranchD &&
        ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
         (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
    assign mdstall      = (MdReadD || MdStartD) && (md_busy || md_accept);
    assign hazard_stall = lwstall || branchstall || mdstall;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        MemErr    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_ae;
            ForwardBE = fwd_be;
            ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
            ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
            MemErr    = timeout_hit;
            // A memory freeze holds every stage and overrides all other hazards.
            if (memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = hazard_stall;
                StallD = hazard_stall;
                FlushE = hazard_stall || jumpD;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((StallF || StallD || StallE || StallM) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if ((FlushE || FlushW) && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign StallCycles = stall_cnt;
    assign FlushCycles = flush_cnt;
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
// ============================================================================
// Module   : tb_hazard_ctrl_mc
// Purpose  : Self-checking bench for hazard_ctrl_mc (directed + random).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_mc;

    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;
    localparam int MEM_TO = 4;
    localparam int PERF_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic BranchD, jumpD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic MdStartD, MdStartE, MdReadD, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic MdBusy, MemErr;
    logic [PERF_W-1:0] StallCycles, FlushCycles;

    logic [5:0] ctl;
    logic [5:0] fwd;
    assign ctl = {StallF, StallD, StallE, StallM, FlushE, FlushW};
    assign fwd = {ForwardAE, ForwardBE, ForwardAD, ForwardBD};

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_HAZ  = 6'b110010;
    localparam logic [5:0] C_MEM  = 6'b111101;
    localparam logic [5:0] C_JMP  = 6'b000010;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(
        .REG_W(REG_W), .MD_LATENCY(MD_LAT), .MEM_TIMEOUT(MEM_TO), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .BranchD(BranchD), .jumpD(jumpD), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MdStartD(MdStartD), .MdStartE(MdStartE), .MdReadD(MdReadD),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MemErr(MemErr),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    task automatic idle();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        BranchD = 0; jumpD = 0; MemtoRegE = 0; RegWriteE = 0;
        MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
        MdStartD = 0; MdStartE = 0; MdReadD = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        RsE = 5; RtE = 5; RsD = 5; WriteRegM = 5; RegWriteM = 1;
        MemtoRegE = 1; jumpD = 1; MemReqM = 1;
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_NONE); end
        checks++;
        if (fwd !== 6'b0) begin errors++; $display("FAIL reset_fwd got %b exp %b", fwd, 6'b0); end
        checks++;
        if ({MdBusy, MemErr} !== 2'b00) begin errors++; $display("FAIL reset_md_err got %b exp 00", {MdBusy, MemErr}); end
        checks++;
        if (StallCycles !== '0 || FlushCycles !== '0) begin
            errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", StallCycles, FlushCycles);
        end
        next_cycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL post_reset_ctl got %b exp %b", ctl, C_NONE); end
        next_cycle();
    endtask

    task automatic test_forward();
        idle();
        RsE = 5; RtE = 5; RsD = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
        @(negedge clk);
        checks++;
        if (fwd !== 6'b10_10_1_0) begin errors++; $display("FAIL fwd_mem_prio got %b exp %b", fwd, 6'b10_10_1_0); end
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL fwd_no_stall got %b exp %b", ctl, C_NONE); end
        WriteRegM = 6;
        #1;
        checks++;
        if (fwd !== 6'b01_01_0_0) begin errors++; $display("FAIL fwd_wb got %b exp %b", fwd, 6'b01_01_0_0); end
        RsE = 0;
        #1;
        checks++;
        if (fwd !== 6'b00_01_0_0) begin errors++; $display("FAIL fwd_r0 got %b exp %b", fwd, 6'b00_01_0_0); end
        RegWriteW = 0; WriteRegM = 7; RtD = 7; RtE = 7;
        #1;
        checks++;
        if (fwd !== 6'b00_10_0_1) begin errors++; $display("FAIL fwd_bd got %b exp %b", fwd, 6'b00_10_0_1); end
        next_cycle();
    endtask

    task automatic test_stalls();
        idle();
        MemtoRegE = 1; RtE = 8; RsD = 8;
        @(negedge clk);
        checks++;
        if (ctl !== C_HAZ) begin errors++; $display("FAIL lwstall got %b exp %b", ctl, C_HAZ); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lwstall_bubble got %b exp %b", ctl, C_NONE); end
        MemtoRegE = 1; RtE = 0; RsD = 0; RtD = 0;
        #1;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lwstall_r0 got %b exp %b", ctl, C_NONE); end
        idle();
        BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3;
        #1;
        checks++;
        if (ctl !== C_HAZ) begin errors++; $display("FAIL branch_e got %b exp %b", ctl, C_HAZ); end
        idle();
        BranchD = 1; MemtoRegM = 1; WriteRegM = 4; RsD = 4;
        #1;
        checks++;
        if (ctl !== C_HAZ) begin errors++; $display("FAIL branch_m got %b exp %b", ctl, C_HAZ); end
        idle();
        jumpD = 1;
        #1;
        checks++;
        if (ctl !== C_JMP) begin errors++; $display("FAIL jump_flush got %b exp %b", ctl, C_JMP); end
        next_cycle();
        idle();
    endtask

    task automatic test_md();
        logic [7:0] stall_seen;
        logic [7:0] busy_seen;
        stall_seen = '0;
        busy_seen  = '0;
        idle();
        MdStartE = 1; MdReadD = 1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) MdStartE = 0;
            @(negedge clk);
            stall_seen[c] = StallD;
            busy_seen[c]  = MdBusy;
            next_cycle();
        end
        checks++;
        if (stall_seen !== 8'b0001_1111) begin errors++; $display("FAIL md_stall_seq got %b exp %b", stall_seen, 8'b0001_1111); end
        checks++;
        if (busy_seen !== 8'b0001_1110) begin errors++; $display("FAIL md_busy_seq got %b exp %b", busy_seen, 8'b0001_1110); end
        idle();
    endtask

    task automatic test_mem_wait();
        idle();
        MemReqM = 1; MemReadyM = 1;
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL mem_ready_first got %b exp %b", ctl, C_NONE); end
        next_cycle();
        MemReadyM = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) MemReadyM = 1;
            @(negedge clk);
            checks++;
            if (ctl !== ((c < 3) ? C_MEM : C_NONE) || MemErr !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait c%0d got %b err %b exp %b err 0", c, ctl, MemErr, (c < 3) ? C_MEM : C_NONE);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_timeout();
        idle();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) MemReqM = 0;
            if (c == 6) MemReqM = 1;
            if (c == 7) MemReadyM = 1;
            @(negedge clk);
            checks++;
            if (ctl !== ((c < 4 || c == 6) ? C_MEM : C_NONE) || MemErr !== (c == 4)) begin
                errors++;
                $display("FAIL timeout c%0d got %b err %b exp %b err %b", c, ctl, MemErr,
                         (c < 4 || c == 6) ? C_MEM : C_NONE, (c == 4));
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        MdStartE = 1;
        next_cycle();
        MdStartE = 0; MemReqM = 1; MemReadyM = 0;
        @(negedge clk);
        checks++;
        if (ctl !== C_MEM || MdBusy !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b busy %b exp %b busy 1", ctl, MdBusy, C_MEM); end
        next_cycle();
        next_cycle();
        RsE = 5; WriteRegM = 5; RegWriteM = 1; jumpD = 1;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NONE || fwd !== 6'b0 || {MdBusy, MemErr} !== 2'b00) begin
            errors++; $display("FAIL rmid_outputs got ctl %b fwd %b busy %b err %b exp all 0", ctl, fwd, MdBusy, MemErr);
        end
        checks++;
        if (StallCycles !== '0 || FlushCycles !== '0) begin
            errors++; $display("FAIL rmid_perf got %0d/%0d exp 0/0", StallCycles, FlushCycles);
        end
        next_cycle();
        reset = 1'b0;
        idle();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) MemReqM = 0;
            @(negedge clk);
            checks++;
            if (MdBusy !== 1'b0 || MemErr !== (c == 4)) begin
                errors++; $display("FAIL rmid_after c%0d got busy %b err %b exp busy 0 err %b", c, MdBusy, MemErr, (c == 4));
            end
            next_cycle();
        end
        idle();
    endtask

    function automatic logic [1:0] exp_fe(input logic [REG_W-1:0] r);
        if (r != 0 && r == WriteRegM && RegWriteM) return 2'b10;
        if (r != 0 && r == WriteRegW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_fd(input logic [REG_W-1:0] r);
        return (r != 0) && (r == WriteRegM) && RegWriteM;
    endfunction

    task automatic test_random();
        int m_wait, m_md;
        logic [PERF_W-1:0] m_sc, m_fc, e_sc, e_fc;
        logic miss, e_err, e_mstall, busy, accept, lw, br, md, s;
        logic [5:0] e_ctl;
        logic [5:0] e_fwd;
        reset = 1'b1;
        idle();
        next_cycle();
        reset = 1'b0;
        m_wait = 0; m_md = 0; m_sc = '0; m_fc = '0;
        for (int n = 0; n < 600; n++) begin
            RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            BranchD   = ($urandom_range(0, 3) == 0);
            jumpD     = ($urandom_range(0, 7) == 0);
            MemtoRegE = 1'($urandom_range(0, 1)); RegWriteE = 1'($urandom_range(0, 1));
            MemtoRegM = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MdStartD  = ($urandom_range(0, 7) == 0);
            MdStartE  = ($urandom_range(0, 5) == 0);
            MdReadD   = ($urandom_range(0, 3) == 0);
            MemReqM   = (m_wait > 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            miss     = MemReqM && !MemReadyM;
            e_err    = miss && (m_wait == MEM_TO);
            e_mstall = miss && !e_err;
            busy     = (m_md > 0);
            accept   = MdStartE && !e_mstall && !busy;
            lw = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE);
            br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                             (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
            md = (MdReadD || MdStartD) && (busy || accept);
            s  = lw || br || md;
            e_ctl = e_mstall ? C_MEM : {s, s, 1'b0, 1'b0, s || jumpD, 1'b0};
            e_fwd = {exp_fe(RsE), exp_fe(RtE), exp_fd(RsD), exp_fd(RtD)};
`ifdef HAZARD_PERF_EN
            e_sc = m_sc; e_fc = m_fc;
`else
            e_sc = '0; e_fc = '0;
`endif
            checks++;
            if (ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl n%0d got %b exp %b", n, ctl, e_ctl); end
            checks++;
            if (fwd !== e_fwd) begin errors++; $display("FAIL rnd_fwd n%0d got %b exp %b", n, fwd, e_fwd); end
            checks++;
            if ({MdBusy, MemErr} !== {busy, e_err}) begin
                errors++; $display("FAIL rnd_busy_err n%0d got %b exp %b", n, {MdBusy, MemErr}, {busy, e_err});
            end
            checks++;
            if (StallCycles !== e_sc || FlushCycles !== e_fc) begin
                errors++; $display("FAIL rnd_perf n%0d got %0d/%0d exp %0d/%0d", n, StallCycles, FlushCycles, e_sc, e_fc);
            end
            if (e_ctl[5:2] != 0 && m_sc != '1) m_sc = m_sc + 1;
            if (e_ctl[1:0] != 0 && m_fc != '1) m_fc = m_fc + 1;
            m_wait = (miss && !e_err) ? m_wait + 1 : 0;
            m_md   = accept ? MD_LAT : ((m_md > 0) ? m_md - 1 : 0);
            next_cycle();
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_stalls();
        test_md();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
